// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for Data_Mem
//
// Accepts one load/store request over a valid/ready handshake, issues it to
// Data_Mem for one cycle and waits MEM_LATENCY cycles for Read_Data on loads.
// It then returns a one-cycle response. Byte loads are lane-selected and
// sign/zero-extended. Misaligned word requests fault without touching memory.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_write/byte/signed         request kind
//   req_addr, req_wdata           byte address, store data
//   resp_valid                    one-cycle response pulse
//   resp_rdata, resp_misaligned   load data (0 for stores/faults), fault flag
//   Mem_Address, Write_Data       Data_Mem request address and data
//   Store_Byte_or_Word            Data_Mem access size (1 = byte)
//   Mem_Write, Mem_Read           Data_Mem strobes (high only in ISSUE)
//   Read_Data                     Data_Mem read data
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Write_Data,
  output logic              Store_Byte_or_Word,
  output logic              Mem_Write,
  output logic              Mem_Read,
  input  logic [DATA_W-1:0] Read_Data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // The counter holds the number of WAIT cycles still to go after this one.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic              r_write;
  logic              r_byte;
  logic              r_signed;
  logic              r_fault;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              fault_in;
  logic [7:0]        lane;
  logic [DATA_W-1:0] byte_ext;

  // Only word accesses care about alignment; byte accesses never fault.
  assign fault_in = ~req_byte & (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      r_write  <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_fault  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_byte   <= req_byte;
            r_signed <= req_signed;
            r_fault  <= fault_in;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            state    <= fault_in ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_write) begin
            state <= S_RESP;
          end else begin
            state <= S_WAIT;
            cnt   <= LAT_LAST;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            r_rdata <= Read_Data;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request-side outputs decode straight from the state register so that an
  // asynchronous reset removes the strobes without waiting for a clock edge.
  assign req_ready          = (state == S_IDLE);
  assign Mem_Write          = (state == S_ISSUE) &  r_write;
  assign Mem_Read           = (state == S_ISSUE) & ~r_write;
  assign Store_Byte_or_Word = r_byte;

  // Byte loads fetch the whole containing word; byte stores keep the full
  // address so Data_Mem can pick the lane itself.
  assign Mem_Address = (r_byte && !r_write) ? {r_addr[ADDR_W-1:2], 2'b00} : r_addr;
  assign Write_Data  = !r_write ? '0 :
                       r_byte   ? {{(DATA_W-8){1'b0}}, r_wdata[7:0]} : r_wdata;

  assign resp_valid      = (state == S_RESP);
  assign resp_misaligned = (state == S_RESP) & r_fault;

  always_comb begin
    lane       = r_rdata[{r_addr[1:0], 3'b000} +: 8];
    byte_ext   = r_signed ? {{(DATA_W-8){lane[7]}}, lane} : {{(DATA_W-8){1'b0}}, lane};
    resp_rdata = '0;
    if (state == S_RESP && !r_write && !r_fault) begin
      resp_rdata = r_byte ? byte_ext : r_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (latency 1 and 3 instances)
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sbw;
    logic        we;
    int          cyc;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic        req_byte [2];
  logic        req_signed [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_misaligned [2];
  logic [31:0] Mem_Address [2];
  logic [31:0] Write_Data [2];
  logic        Store_Byte_or_Word [2];
  logic        Mem_Write [2];
  logic        Mem_Read [2];
  logic [31:0] Read_Data [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  rsp_t  rq [2][$];
  mreq_t mq [2][$];

  // Data_Mem model: Read_Data is only meaningful during the cycle that is
  // MEM_LATENCY cycles after the Mem_Read strobe; otherwise it shows garbage.
  logic [31:0] mem [2][16] = '{'{0: 32'h8A00_0000, 2: 32'h80FF_7F01, default: 32'h0},
                               '{0: 32'h8A00_0000, 2: 32'h80FF_7F01, default: 32'h0}};
  logic [31:0] rd_addr [2] = '{32'h0, 32'h0};
  int          rd_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Mem_Write[i]) begin
        if (Store_Byte_or_Word[i])
          mem[i][Mem_Address[i][5:2]][{Mem_Address[i][1:0], 3'b000} +: 8] <= Write_Data[i][7:0];
        else
          mem[i][Mem_Address[i][5:2]] <= Write_Data[i];
      end
      if (Mem_Read[i]) begin
        rd_addr[i] <= Mem_Address[i];
        rd_cnt[i]  <= (i == 0) ? 1 : 3;
      end else if (rd_cnt[i] != 0) begin
        rd_cnt[i] <= rd_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      Read_Data[i] = (rd_cnt[i] == 1) ? mem[i][rd_addr[i][5:2]] : 32'hDEAD_BEEF;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY((g == 0) ? 1 : 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_byte(req_byte[g]), .req_signed(req_signed[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
      .resp_misaligned(resp_misaligned[g]),
      .Mem_Address(Mem_Address[g]), .Write_Data(Write_Data[g]),
      .Store_Byte_or_Word(Store_Byte_or_Word[g]),
      .Mem_Write(Mem_Write[g]), .Mem_Read(Mem_Read[g]), .Read_Data(Read_Data[g])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    rsp_t  r;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (Mem_Write[i] && Mem_Read[i]) begin
            errors++;
            $display("FAIL strobe_overlap inst %0d cyc %0d", i, cyc);
          end
          if (resp_misaligned[i] && !resp_valid[i]) begin
            errors++;
            $display("FAIL misaligned_without_valid inst %0d cyc %0d", i, cyc);
          end
          if (Mem_Write[i] || Mem_Read[i]) begin
            checks++;
            if (mq[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_strobe inst %0d cyc %0d addr %h", i, cyc, Mem_Address[i]);
            end else begin
              m = mq[i].pop_front();
              if (cyc != m.cyc || Mem_Address[i] !== m.addr || Write_Data[i] !== m.wdata ||
                  Store_Byte_or_Word[i] !== m.sbw || Mem_Write[i] !== m.we || Mem_Read[i] === m.we) begin
                errors++;
                $display("FAIL mem_req inst %0d: got cyc %0d addr %h wdata %h sbw %b wr %b rd %b expected cyc %0d addr %h wdata %h sbw %b wr %b",
                         i, cyc, Mem_Address[i], Write_Data[i], Store_Byte_or_Word[i], Mem_Write[i], Mem_Read[i],
                         m.cyc, m.addr, m.wdata, m.sbw, m.we);
              end
            end
          end
          if (resp_valid[i]) begin
            checks++;
            if (rq[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_resp inst %0d cyc %0d rdata %h", i, cyc, resp_rdata[i]);
            end else begin
              r = rq[i].pop_front();
              if (cyc != r.cyc || resp_rdata[i] !== r.rdata || resp_misaligned[i] !== r.mis) begin
                errors++;
                $display("FAIL resp inst %0d: got cyc %0d rdata %h mis %b expected cyc %0d rdata %h mis %b",
                         i, cyc, resp_rdata[i], resp_misaligned[i], r.cyc, r.rdata, r.mis);
              end
            end
          end
        end
      end
    end
  endtask

  // Presents a request, waits for acceptance and queues the expected memory
  // request and response. acc is the cycle in which the accept edge closes.
  task automatic issue(input int i, input logic w, input logic b, input logic s,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rd, input logic e_mis,
                       input logic [31:0] e_a, input logic [31:0] e_wd,
                       input bit keep, output int acc);
    int    n = 0;
    int    lat;
    rsp_t  r;
    mreq_t m;
    req_valid[i] = 1'b1; req_write[i] = w; req_byte[i] = b; req_signed[i] = s;
    req_addr[i] = a; req_wdata[i] = wd;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout inst %0d addr %h", i, a);
      req_valid[i] = 1'b0;
      return;
    end
    lat = e_mis ? 1 : (w ? 2 : 2 + ((i == 0) ? 1 : 3));
    r.rdata = e_rd; r.mis = e_mis; r.cyc = acc + lat;
    rq[i].push_back(r);
    if (!e_mis) begin
      m.addr = e_a; m.wdata = e_wd; m.sbw = b; m.we = w; m.cyc = acc + 1;
      mq[i].push_back(m);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq[0].size() + rq[1].size() + mq[0].size() + mq[1].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout pending %0d/%0d", rq[0].size(), rq[1].size());
      for (int i = 0; i < 2; i++) begin
        rq[i].delete();
        mq[i].delete();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, a2;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_byte[i] = 1'b0; req_signed[i] = 1'b0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
      end
    join_none

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_strobes", {30'd0, Mem_Write[i], Mem_Read[i]}, 32'd0);
      check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      check("rst_mem_address", Mem_Address[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // word store then word load
    issue(0, 1, 0, 0, 32'd4, 32'd1001, 32'd0, 0, 32'd4, 32'd1001, 0, a0);
    drain();
    issue(0, 0, 0, 0, 32'd4, 32'd0, 32'd1001, 0, 32'd4, 32'd0, 0, a0);
    drain();

    // byte loads from word 8 = 80FF_7F01
    issue(0, 0, 1, 1, 32'd9,  32'd0, 32'h0000_007F, 0, 32'd8, 32'd0, 0, a0); drain();
    issue(0, 0, 1, 1, 32'd11, 32'd0, 32'hFFFF_FF80, 0, 32'd8, 32'd0, 0, a0); drain();
    issue(0, 0, 1, 0, 32'd10, 32'd0, 32'h0000_00FF, 0, 32'd8, 32'd0, 0, a0); drain();
    issue(0, 0, 1, 0, 32'd8,  32'd0, 32'h0000_0001, 0, 32'd8, 32'd0, 0, a0); drain();
    issue(0, 0, 1, 1, 32'd3,  32'd0, 32'hFFFF_FF8A, 0, 32'd0, 32'd0, 0, a0); drain();

    // byte store into lane 2 of word 4, then read the word back
    issue(0, 1, 1, 0, 32'd6, 32'h1234_56AB, 32'd0, 0, 32'd6, 32'h0000_00AB, 0, a0); drain();
    issue(0, 0, 0, 0, 32'd4, 32'd0, 32'h00AB_03E9, 0, 32'd4, 32'd0, 0, a0); drain();

    // misaligned word accesses fault with no strobe
    issue(0, 0, 0, 0, 32'd2, 32'd0, 32'd0, 1, 32'd0, 32'd0, 0, a0); drain();
    issue(0, 1, 0, 0, 32'd7, 32'h5555_5555, 32'd0, 1, 32'd0, 32'd0, 0, a0); drain();

    // back-to-back stores with req_valid held high
    issue(0, 1, 0, 0, 32'd12, 32'h0000_0C0C, 32'd0, 0, 32'd12, 32'h0000_0C0C, 1, a0);
    issue(0, 1, 0, 0, 32'd16, 32'h0000_1010, 32'd0, 0, 32'd16, 32'h0000_1010, 1, a1);
    issue(0, 1, 1, 0, 32'd21, 32'hFFFF_FF77, 32'd0, 0, 32'd21, 32'h0000_0077, 0, a2);
    check("store_spacing_1", 32'(a1 - a0), 32'd3);
    check("store_spacing_2", 32'(a2 - a1), 32'd3);
    drain();

    // back-to-back loads, latency 1
    issue(0, 0, 0, 0, 32'd12, 32'd0, 32'h0000_0C0C, 0, 32'd12, 32'd0, 1, a0);
    issue(0, 0, 1, 0, 32'd21, 32'd0, 32'h0000_0077, 0, 32'd20, 32'd0, 0, a1);
    check("load_spacing_lat1", 32'(a1 - a0), 32'd4);
    drain();

    // back-to-back loads, latency 3
    issue(1, 0, 0, 0, 32'd8,  32'd0, 32'h80FF_7F01, 0, 32'd8, 32'd0, 1, a0);
    issue(1, 0, 1, 1, 32'd11, 32'd0, 32'hFFFF_FF80, 0, 32'd8, 32'd0, 1, a1);
    issue(1, 1, 0, 0, 32'd0,  32'h0BAD_F00D, 32'd0, 0, 32'd0, 32'h0BAD_F00D, 0, a2);
    check("load_spacing_lat3", 32'(a1 - a0), 32'd6);
    check("load_to_store_spacing_lat3", 32'(a2 - a1), 32'd6);
    drain();

    // reset in the middle of a latency-3 load
    issue(1, 0, 0, 0, 32'd8, 32'd0, 32'h80FF_7F01, 0, 32'd8, 32'd0, 0, a0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    check("midrst_strobes", {30'd0, Mem_Write[1], Mem_Read[1]}, 32'd0);
    check("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
    rq[1].delete();
    mq[1].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1, 0, 1, 1, 32'd9, 32'd0, 32'h0000_007F, 0, 32'd8, 32'd0, 0, a0); drain();
    issue(1, 0, 0, 0, 32'd0, 32'd0, 32'h0BAD_F00D, 0, 32'd0, 32'd0, 0, a0); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
